// File: rtl/reg_file_mp.sv
// Multi-port register file: NRD registered read ports, two write ports
// (wr1 wins), write-first bypass, optional zero r0 and a busy scoreboard.
module reg_file_mp #(
    parameter int DATA_W  = 32,
    parameter int NREG    = 32,
    parameter int ADDR_W  = $clog2(NREG),
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic                  wr0_en,
    input  logic [ADDR_W-1:0]     wr0_addr,
    input  logic [DATA_W-1:0]     wr0_data,
    input  logic                  wr1_en,
    input  logic [ADDR_W-1:0]     wr1_addr,
    input  logic [DATA_W-1:0]     wr1_data,
    input  logic                  busy_set_en,
    input  logic [ADDR_W-1:0]     busy_set_addr,
    output logic [NREG-1:0]       busy,
    output logic                  wr_conflict
);

    localparam bit ZR  = (ZERO_R0 != 0);
    localparam bit BYP = (BYPASS != 0);

    logic [DATA_W-1:0]     regs [NREG];
    logic                  w0_ok;
    logic                  w1_ok;
    logic                  same;
    logic [NRD*DATA_W-1:0] rd_nxt;
    logic [NREG-1:0]       busy_nxt;

    // Writes to a hardwired r0 are treated as if never issued.
    assign w0_ok = wr0_en && !(ZR && wr0_addr == '0);
    assign w1_ok = wr1_en && !(ZR && wr1_addr == '0);
    assign same  = w0_ok && w1_ok && (wr0_addr == wr1_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (w0_ok && !same) begin
                regs[wr0_addr] <= wr0_data;
            end
            if (w1_ok) begin
                regs[wr1_addr] <= wr1_data;
            end
        end
    end

    always_comb begin : rd_mux
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] v;
        a      = '0;
        v      = '0;
        rd_nxt = '0;
        for (int k = 0; k < NRD; k++) begin
            a = rd_addr[k*ADDR_W +: ADDR_W];
            v = regs[a];
            if (BYP) begin
                if (w0_ok && wr0_addr == a) begin
                    v = wr0_data;
                end
                if (w1_ok && wr1_addr == a) begin
                    v = wr1_data;
                end
            end
            if (ZR && a == '0) begin
                v = '0;
            end
            rd_nxt[k*DATA_W +: DATA_W] = v;
        end
    end

    // A new issue to a register beats the retirement of its older producer.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < NREG; i++) begin
            if (busy_set_en && busy_set_addr == ADDR_W'(i)) begin
                busy_nxt[i] = 1'b1;
            end else if ((wr0_en && wr0_addr == ADDR_W'(i)) ||
                         (wr1_en && wr1_addr == ADDR_W'(i))) begin
                busy_nxt[i] = 1'b0;
            end
        end
        if (ZR) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data     <= '0;
            busy        <= '0;
            wr_conflict <= 1'b0;
        end else begin
            rd_data     <= rd_nxt;
            busy        <= busy_nxt;
            wr_conflict <= same;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed cases then random traffic against an
// array model; a BYPASS=0 copy shares the stimulus.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int NP = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NP*AW-1:0] rd_addr = '0;
    logic [NP*DW-1:0] rd_data;
    logic [NP*DW-1:0] rd_data_nb;
    logic             wr0_en = 1'b0;
    logic [AW-1:0]    wr0_addr = '0;
    logic [DW-1:0]    wr0_data = '0;
    logic             wr1_en = 1'b0;
    logic [AW-1:0]    wr1_addr = '0;
    logic [DW-1:0]    wr1_data = '0;
    logic             busy_set_en = 1'b0;
    logic [AW-1:0]    busy_set_addr = '0;
    logic [NR-1:0]    busy;
    logic [NR-1:0]    busy_nb;
    logic             wr_conflict;
    logic             wr_conflict_nb;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_reg [NR];
    logic [NR-1:0] m_busy;
    logic          m_conf;
    logic [DW-1:0] m_rd_b [NP];
    logic [DW-1:0] m_rd_n [NP];

    always #5 clk = ~clk;

    reg_file_mp #(.BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
        .busy(busy), .wr_conflict(wr_conflict)
    );

    reg_file_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
        .busy(busy_nb), .wr_conflict(wr_conflict_nb)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_reg[i] = '0;
        m_busy = '0;
        m_conf = 1'b0;
        for (int k = 0; k < NP; k++) begin
            m_rd_b[k] = '0;
            m_rd_n[k] = '0;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < NP; k++) begin
            chk({tag, "_rd_byp"}, 64'(rd_data[k*DW +: DW]), 64'(m_rd_b[k]));
            chk({tag, "_rd_nob"}, 64'(rd_data_nb[k*DW +: DW]), 64'(m_rd_n[k]));
        end
        chk({tag, "_busy"}, 64'(busy), 64'(m_busy));
        chk({tag, "_busy_nb"}, 64'(busy_nb), 64'(m_busy));
        chk({tag, "_conf"}, 64'(wr_conflict), 64'(m_conf));
        chk({tag, "_conf_nb"}, 64'(wr_conflict_nb), 64'(m_conf));
    endtask

    // Reference: r0 is constant zero; wr1 lands last; reads see the
    // committed value (old) or the freshest same-edge write (bypassed).
    task automatic step(input string tag);
        logic [AW-1:0] a;
        logic [DW-1:0] newest [NR];
        for (int i = 0; i < NR; i++) newest[i] = m_reg[i];
        if (wr0_en && wr0_addr != 0) newest[wr0_addr] = wr0_data;
        if (wr1_en && wr1_addr != 0) newest[wr1_addr] = wr1_data;
        for (int k = 0; k < NP; k++) begin
            a = rd_addr[k*AW +: AW];
            m_rd_n[k] = m_reg[a];
            m_rd_b[k] = newest[a];
        end
        m_conf = wr0_en && wr1_en && wr0_addr == wr1_addr && wr0_addr != 0;
        if (wr0_en) m_busy[wr0_addr] = 1'b0;
        if (wr1_en) m_busy[wr1_addr] = 1'b0;
        if (busy_set_en) m_busy[busy_set_addr] = 1'b1;
        m_busy[0] = 1'b0;
        for (int i = 0; i < NR; i++) m_reg[i] = newest[i];
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle();
        wr0_en = 1'b0;
        wr1_en = 1'b0;
        busy_set_en = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        check_outputs("reset");
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic write then read
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h0000_00F0;
        step("t2_wr");
        idle();
        rd_addr[0 +: AW] = 5'd3;
        step("t2_rd");
        chk("t2_val", 64'(rd_data[0 +: DW]), 64'h0000_00F0);

        // bypass vs no bypass
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
        step("t3_pre");
        wr0_data = 32'h15; rd_addr[AW +: AW] = 5'd7;
        step("t3_byp");
        chk("t3_byp_val", 64'(rd_data[DW +: DW]), 64'h15);
        chk("t3_nob_val", 64'(rd_data_nb[DW +: DW]), 64'h11);
        idle();
        step("t3_after");
        chk("t3_nob_late", 64'(rd_data_nb[DW +: DW]), 64'h15);

        // write conflict
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'hAAAA;
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'hBBBB;
        rd_addr[0 +: AW] = 5'd9;
        step("t4_conf");
        chk("t4_pulse", 64'(wr_conflict), 64'd1);
        chk("t4_byp", 64'(rd_data[0 +: DW]), 64'hBBBB);
        idle();
        step("t4_drop");
        chk("t4_pulse_end", 64'(wr_conflict), 64'd0);
        chk("t4_stored", 64'(rd_data_nb[0 +: DW]), 64'hBBBB);

        // r0 hardwired
        wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFF_FFFF;
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'h1234;
        busy_set_en = 1'b1; busy_set_addr = 5'd0;
        rd_addr = '0;
        step("t5_w");
        chk("t5_conf", 64'(wr_conflict), 64'd0);
        idle();
        step("t5_r");
        chk("t5_rd0", 64'(rd_data[0 +: DW]), 64'd0);
        chk("t5_busy0", 64'(busy[0]), 64'd0);

        // scoreboard
        busy_set_en = 1'b1; busy_set_addr = 5'd4;
        step("t6_set");
        chk("t6_set_b", 64'(busy[4]), 64'd1);
        wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h44;
        step("t6_setwin");
        chk("t6_setwin_b", 64'(busy[4]), 64'd1);
        idle();
        wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h45;
        step("t6_clr");
        chk("t6_clr_b", 64'(busy[4]), 64'd0);
        idle();

        // random traffic, narrow address range half the time
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] lim;
            lim = ($urandom_range(0, 1) == 0) ? 5'd7 : 5'd31;
            wr0_en        = 1'($urandom_range(0, 1));
            wr0_addr      = AW'($urandom_range(0, int'(lim)));
            wr0_data      = $urandom;
            wr1_en        = 1'($urandom_range(0, 1));
            wr1_addr      = AW'($urandom_range(0, int'(lim)));
            wr1_data      = $urandom;
            busy_set_en   = 1'($urandom_range(0, 1));
            busy_set_addr = AW'($urandom_range(0, int'(lim)));
            for (int k = 0; k < NP; k++)
                rd_addr[k*AW +: AW] = AW'($urandom_range(0, int'(lim)));
            step("rnd");
        end

        // asynchronous reset mid-run, then read r5
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEAD;
        busy_set_en = 1'b1; busy_set_addr = 5'd6;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("t1_async");
        #3;
        idle();
        rst_n = 1'b1;
        rd_addr[0 +: AW] = 5'd5;
        step("t1_rel");
        step("t1_rd");
        chk("t1_r5", 64'(rd_data[0 +: DW]), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
